// File: rtl/fill_port_responder_pkg.sv
// Shared definitions for the SDRAM-side cache line-fill responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fill_port_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_COLLECT = 2'd2,
      ST_EMIT    = 2'd3
   } state_t;

   localparam int BURST_LEN = 4;
   localparam int IDXW      = 2;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BURST_LEN - 1);

   // Optional fill statistics widths.
   localparam int LATW = 8;
   localparam int CNTW = 16;

endpackage

// File: rtl/fill_port_responder_line_buffer.sv
// Four-word line buffer: one synchronous write port, one combinational read port.
// Latency: write visible on read port the cycle after i_we; read is combinational.
// Backpressure: none; every write is accepted. Contents are deliberately not reset.
//
// Ports: clk, i_we/i_wr_idx/i_wr_dat (write), i_rd_idx/o_rd_dat (read).
module fill_line_buffer
   import fill_port_responder_pkg::*;
#(
   parameter int DATAW = 16
)
(
   input  logic             clk,
   input  logic             i_we,
   input  logic [IDXW-1:0]  i_wr_idx,
   input  logic [DATAW-1:0] i_wr_dat,
   input  logic [IDXW-1:0]  i_rd_idx,
   output logic [DATAW-1:0] o_rd_dat
);

   logic [DATAW-1:0] r_mem [BURST_LEN];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_wr_idx] <= i_wr_dat;
      end
   end

   assign o_rd_dat = r_mem[i_rd_idx];

endmodule

// File: rtl/fill_port_responder.sv
// Cache line-fill responder: one 4-word SDRAM burst read, replayed critical-word-first.
// Latency: ctl_req 1 cycle after cache_req; cache_fill 1 cycle after the 4th ctl_valid, words on 4 consecutive cycles.
// Backpressure: ctl_req held until ctl_ack; cache side has none (fixed 4-cycle replay); new requests only taken in IDLE.
//
// Ports: clk/reset_n; cache_req/cache_addr in, cache_fill/cache_data out (cache side);
//        ctl_req/ctl_addr out, ctl_ack/ctl_valid/ctl_data in (SDRAM controller side).
// Optional: define FILLPORT_STATS_EN to add fill_count and fill_latency outputs.
module fill_port_responder
   import fill_port_responder_pkg::*;
#(
   parameter int ADDRW = 25,
   parameter int DATAW = 16
)
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cache_req,
   input  logic [31:0]        cache_addr,
   output logic               cache_fill,
   output logic [DATAW-1:0]   cache_data,
   output logic               ctl_req,
   output logic [ADDRW-3:0]   ctl_addr,
   input  logic               ctl_ack,
   input  logic               ctl_valid,
   input  logic [DATAW-1:0]   ctl_data
`ifdef FILLPORT_STATS_EN
   ,
   output logic [CNTW-1:0]    fill_count,
   output logic [LATW-1:0]    fill_latency
`endif
);

   state_t           r_state;
   logic [IDXW-1:0]  r_cnt;       // word counter while collecting, replay counter while emitting
   logic [IDXW-1:0]  r_crit;
   logic             r_ctl_req;
   logic [ADDRW-3:0] r_ctl_addr;
   logic             r_fill;
   logic [DATAW-1:0] r_data;

   logic             w_we;
   logic [IDXW-1:0]  w_rd_idx;
   logic [DATAW-1:0] w_rd_dat;
   logic [DATAW-1:0] w_first;
   logic             w_unused;

   assign w_unused = ^{cache_addr[31:ADDRW+1], cache_addr[0]};

   // A word arriving in the ack cycle is word 0; strays before ack are dropped.
   assign w_we = ctl_valid && ((r_state == ST_ISSUE && ctl_ack) || r_state == ST_COLLECT);

   // While emitting, fetch the word for the next replay cycle.
   assign w_rd_idx = (r_state == ST_EMIT) ? (r_crit + r_cnt + IDXW'(1)) : r_crit;

   // Critical word may be the one arriving right now (crit==3); bypass the buffer.
   assign w_first = (r_crit == r_cnt) ? ctl_data : w_rd_dat;

   fill_line_buffer #(.DATAW(DATAW)) u_buf (
      .clk      (clk),
      .i_we     (w_we),
      .i_wr_idx (r_cnt),
      .i_wr_dat (ctl_data),
      .i_rd_idx (w_rd_idx),
      .o_rd_dat (w_rd_dat)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_crit     <= '0;
         r_ctl_req  <= 1'b0;
         r_ctl_addr <= '0;
         r_fill     <= 1'b0;
         r_data     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_fill <= 1'b0;
               if (cache_req) begin
                  r_ctl_addr <= cache_addr[ADDRW:3];
                  r_crit     <= cache_addr[2:1];
                  r_cnt      <= '0;
                  r_ctl_req  <= 1'b1;
                  r_state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (ctl_ack) begin
                  r_ctl_req <= 1'b0;
                  r_state   <= ST_COLLECT;
                  if (ctl_valid) begin
                     r_cnt <= r_cnt + IDXW'(1);
                  end
               end
            end
            ST_COLLECT: begin
               if (ctl_valid) begin
                  r_cnt <= r_cnt + IDXW'(1);   // wraps to 0 on the last word, ready for replay
                  if (r_cnt == LAST_IDX) begin
                     r_fill  <= 1'b1;
                     r_data  <= w_first;
                     r_state <= ST_EMIT;
                  end
               end
            end
            ST_EMIT: begin
               r_fill <= 1'b0;
               if (r_cnt == LAST_IDX) begin
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_data <= w_rd_dat;
                  r_cnt  <= r_cnt + IDXW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign cache_fill = r_fill;
   assign cache_data = r_data;
   assign ctl_req    = r_ctl_req;
   assign ctl_addr   = r_ctl_addr;

`ifdef FILLPORT_STATS_EN
   logic [LATW-1:0] r_lat_run;
   logic [LATW-1:0] r_fill_latency;
   logic [CNTW-1:0] r_fill_count;

   // r_lat_run counts cycles since ctl_req rose; at the cache_fill cycle it equals that distance.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lat_run      <= '0;
         r_fill_latency <= '0;
         r_fill_count   <= '0;
      end else begin
         if (r_state == ST_IDLE && cache_req) begin
            r_lat_run <= '0;
         end else if ((r_state == ST_ISSUE || r_state == ST_COLLECT) && r_lat_run != '1) begin
            r_lat_run <= r_lat_run + LATW'(1);
         end
         if (r_fill) begin
            r_fill_latency <= r_lat_run;
            if (r_fill_count != '1) begin
               r_fill_count <= r_fill_count + CNTW'(1);
            end
         end
      end
   end

   assign fill_count   = r_fill_count;
   assign fill_latency = r_fill_latency;
`endif

endmodule

// File: tb/tb_fill_port_responder.sv
// Self-checking bench for fill_port_responder: transaction-level model plus directed fills.
// Latency: n/a.
// Backpressure: n/a.
module tb_fill_port_responder;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cache_req = 1'b0;
   logic [31:0] cache_addr = '0;
   logic        cache_fill;
   logic [15:0] cache_data;
   logic        ctl_req;
   logic [22:0] ctl_addr;
   logic        ctl_ack = 1'b0;
   logic        ctl_valid = 1'b0;
   logic [15:0] ctl_data = '0;
`ifdef FILLPORT_STATS_EN
   logic [15:0] fill_count;
   logic [7:0]  fill_latency;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fill_port_responder #(.ADDRW(25), .DATAW(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cache_req  (cache_req),
      .cache_addr (cache_addr),
      .cache_fill (cache_fill),
      .cache_data (cache_data),
      .ctl_req    (ctl_req),
      .ctl_addr   (ctl_addr),
      .ctl_ack    (ctl_ack),
      .ctl_valid  (ctl_valid),
      .ctl_data   (ctl_data)
`ifdef FILLPORT_STATS_EN
      ,
      .fill_count   (fill_count),
      .fill_latency (fill_latency)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   bit          m_busy = 0;
   bit          m_wait_ack = 0;
   bit          m_emitting = 0;
   bit          m_fill_prev = 0;
   int          m_crit = 0;
   int          m_cyc = 0;
   logic [15:0] m_words[$];
   logic [15:0] m_out[$];
   logic        exp_req = 1'b0;
   logic        exp_fill = 1'b0;
   logic [15:0] exp_data = '0;
   logic [22:0] exp_addr = '0;
   logic [15:0] exp_count = '0;
   logic [7:0]  exp_lat = '0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_busy = 0; m_wait_ack = 0; m_emitting = 0; m_fill_prev = 0;
         m_words.delete(); m_out.delete();
         exp_req = 0; exp_fill = 0; exp_data = '0; exp_addr = '0;
         exp_count = '0; exp_lat = '0; m_cyc = 0;
      end else begin
         if (m_fill_prev) begin
            if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
            exp_lat = (m_cyc > 255) ? 8'd255 : 8'(m_cyc);
         end
         m_fill_prev = 0;
         exp_fill = 0;
         if (!m_busy) begin
            if (cache_req) begin
               m_busy = 1; m_wait_ack = 1; exp_req = 1;
               exp_addr = cache_addr[25:3];
               m_crit = int'(cache_addr[2:1]);
               m_words.delete();
               m_cyc = 0;
            end
         end else if (!m_emitting) begin
            m_cyc++;
            if (m_wait_ack) begin
               if (ctl_ack) begin
                  m_wait_ack = 0; exp_req = 0;
                  if (ctl_valid) m_words.push_back(ctl_data);
               end
            end else if (ctl_valid) begin
               m_words.push_back(ctl_data);
               if (m_words.size() == 4) begin
                  for (int k = 0; k < 4; k++) m_out.push_back(m_words[(m_crit + k) % 4]);
                  m_emitting = 1; exp_fill = 1; m_fill_prev = 1;
                  exp_data = m_out.pop_front();
               end
            end
         end else begin
            if (m_out.size() > 0) exp_data = m_out.pop_front();
            else begin m_busy = 0; m_emitting = 0; end
         end
      end
   end

   always @(negedge clk) begin
      chk("mdl_ctl_req", ctl_req, exp_req);
      chk("mdl_ctl_addr", ctl_addr, exp_addr);
      chk("mdl_cache_fill", cache_fill, exp_fill);
      chk("mdl_cache_data", cache_data, exp_data);
`ifdef FILLPORT_STATS_EN
      chk("mdl_fill_count", fill_count, exp_count);
      chk("mdl_fill_latency", fill_latency, exp_lat);
`endif
   end

   // ---------------- directed stimulus ----------------
   task automatic do_reset();
      @(posedge clk);
      #2 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // vt* are valid offsets from the ack cycle (strictly increasing); e* the hand-computed replay order.
   task automatic run_fill(input string tag, input logic [31:0] addr, input logic [22:0] eaddr,
                           input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3,
                           input int ack_dly, input int vt0, input int vt1, input int vt2, input int vt3,
                           input bit stray,
                           input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
      logic [15:0] w [4];
      int          vt [4];
      w  = '{w0, w1, w2, w3};
      vt = '{vt0, vt1, vt2, vt3};
      @(negedge clk);
      cache_req = 1'b1; cache_addr = addr;
      @(negedge clk);
      cache_req = 1'b0;
      chk({tag, "_req_rise"}, ctl_req, 1'b1);
      chk({tag, "_ctl_addr"}, ctl_addr, eaddr);
      for (int i = 0; i < ack_dly; i++) begin
         ctl_valid = stray; ctl_data = 16'hBAD0;
         @(negedge clk);
         chk({tag, "_req_hold"}, ctl_req, 1'b1);
      end
      for (int t = 0; t <= vt[3]; t++) begin
         ctl_ack = (t == 0);
         ctl_valid = 1'b0;
         for (int k = 0; k < 4; k++) begin
            if (vt[k] == t) begin ctl_valid = 1'b1; ctl_data = w[k]; end
         end
         @(negedge clk);
         if (t == 0) chk({tag, "_req_drop"}, ctl_req, 1'b0);
      end
      // One cycle after the 4th word: fill strobe; also push a 5th word that must be ignored.
      ctl_ack = 1'b0; ctl_valid = 1'b1; ctl_data = 16'hDEAD;
      chk({tag, "_fill_e0"}, cache_fill, 1'b1);
      chk({tag, "_data_e0"}, cache_data, e0);
      @(negedge clk);
      ctl_valid = 1'b0;
      chk({tag, "_fill_e1"}, cache_fill, 1'b0);
      chk({tag, "_data_e1"}, cache_data, e1);
      @(negedge clk);
      chk({tag, "_data_e2"}, cache_data, e2);
      @(negedge clk);
      chk({tag, "_data_e3"}, cache_data, e3);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ctl_req", ctl_req, 1'b0);
      chk("rst_cache_fill", cache_fill, 1'b0);
      chk("rst_cache_data", cache_data, 16'h0000);
      chk("rst_ctl_addr", ctl_addr, 23'h0);
      reset_n = 1'b1;

      run_fill("crit0", 32'h0001_2340, 23'h002468, 16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3,
               1, 0, 1, 2, 3, 0, 16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3);
      run_fill("crit2", 32'h0000_100C, 23'h000201, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
               2, 0, 1, 2, 3, 0, 16'h3333, 16'h4444, 16'h1111, 16'h2222);
      run_fill("gap", 32'h0000_0006, 23'h000000, 16'hC000, 16'hC001, 16'hC002, 16'hC003,
               1, 0, 3, 4, 9, 0, 16'hC003, 16'hC000, 16'hC001, 16'hC002);
      run_fill("ackdly", 32'h0000_0002, 23'h000000, 16'hD000, 16'hD001, 16'hD002, 16'hD003,
               7, 0, 1, 2, 3, 1, 16'hD001, 16'hD002, 16'hD003, 16'hD000);

      // Reset while collecting, after two words.
      @(negedge clk);
      cache_req = 1'b1; cache_addr = 32'h0000_0ABC;
      @(negedge clk);
      cache_req = 1'b0; ctl_ack = 1'b1; ctl_valid = 1'b1; ctl_data = 16'h5555;
      @(negedge clk);
      ctl_ack = 1'b0; ctl_data = 16'h6666;
      @(negedge clk);
      ctl_valid = 1'b0;
      do_reset();
      chk("rst_mid_req", ctl_req, 1'b0);
      for (int i = 0; i < 8; i++) begin
         ctl_valid = (i < 2); ctl_data = 16'h7777;
         @(negedge clk);
         chk("rst_mid_nofill", cache_fill, 1'b0);
      end
      ctl_valid = 1'b0;
      run_fill("after_rst", 32'h0000_0F02, 23'h0001E0, 16'hE000, 16'hE001, 16'hE002, 16'hE003,
               1, 0, 1, 2, 3, 0, 16'hE001, 16'hE002, 16'hE003, 16'hE000);

      // Statistics: three identical fills (ack after 2 cycles, words from ack+1), then a long one.
      do_reset();
`ifdef FILLPORT_STATS_EN
      chk("stat_rst_count", fill_count, 16'd0);
      chk("stat_rst_lat", fill_latency, 8'd0);
`endif
      for (int n = 0; n < 3; n++) begin
         run_fill("stat", 32'h0000_0010, 23'h000002, 16'h0F00, 16'h0F01, 16'h0F02, 16'h0F03,
                  2, 1, 2, 3, 4, 0, 16'h0F00, 16'h0F01, 16'h0F02, 16'h0F03);
      end
`ifdef FILLPORT_STATS_EN
      chk("stat_count3", fill_count, 16'd3);
      chk("stat_lat7", fill_latency, 8'd7);
`endif
      run_fill("statsat", 32'h0000_0004, 23'h000000, 16'h0B00, 16'h0B01, 16'h0B02, 16'h0B03,
               300, 0, 1, 2, 3, 0, 16'h0B02, 16'h0B03, 16'h0B00, 16'h0B01);
`ifdef FILLPORT_STATS_EN
      chk("stat_count4", fill_count, 16'd4);
      chk("stat_lat_sat", fill_latency, 8'd255);
`endif

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
